multi_mode_counter: RTL
=======================

Name: multi_mode_counter

Overview:
Parametrised successor to the single up/down terminal counter. Provides NUM_CH independent counter channels on one clock. Each channel has a runtime-selectable direction, wrap or one-shot mode, synchronous clear and load, a registered terminal-count pulse and a sticky done flag. It serves as the shared timing resource for the UART datapath: baud division, bit counting and timeout supervision.

Parameters:
CNT_W, 8, width of each channel's count and goal.
NUM_CH, 2, number of independent channels.
PRESCALE_W, 8, prescaler width; used only when the optional feature is enabled.

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-high.
en  in  NUM_CH  per-channel count enable.
clr  in  NUM_CH  per-channel synchronous clear.
load  in  NUM_CH  per-channel synchronous load.
load_val  in  NUM_CH*CNT_W  load values, channel i at bits [i*CNT_W +: CNT_W].
dir  in  NUM_CH  0 = up (CNT_UP), 1 = down (CNT_DOWN).
mode  in  NUM_CH  0 = wrap (CNT_WRAP), 1 = one-shot (CNT_ONESHOT).
goal  in  NUM_CH*CNT_W  per-channel terminal value for up counting and reload value for down counting.
prescale_div  in  PRESCALE_W  prescaler divisor; ignored when the optional feature is disabled.
count  out  NUM_CH*CNT_W  registered count per channel.
at_term  out  NUM_CH  combinational, high when the channel is at its terminal value.
tc  out  NUM_CH  registered one-cycle terminal-count pulse.
done  out  NUM_CH  sticky flag, set only in one-shot mode.

Behaviour:
- Reset (rst=1, asynchronous): count=0, tc=0, done=0 on all channels. Prescaler counter=0.
- Start value: up = 0; down = goal.
- Terminal condition (at_term):
  - up: count >= goal. Using >= covers goal being lowered below the current count.
  - down: count == 0.
- Per-channel priority each clk edge: clr > load > step > hold.
- clr: count <= start value for the current dir; done <= 0; tc <= 0.
- load: count <= load_val; done <= 0; tc <= 0. No range check; an up-load above goal is terminal on the next step.
- step occurs when en=1, done=0 and step_tick=1 (step_tick is constant 1 without the optional feature).
  - Non-terminal step: count <= count+1 (up) or count-1 (down); tc <= 0.
  - Terminal step, wrap mode: count <= start value; tc <= 1 for exactly one cycle.
  - Terminal step, one-shot mode: count holds; done <= 1; tc <= 1 for one cycle.
- While done=1: count and done hold and tc=0 until clr or load. en is ignored.
- No step (en=0 or step_tick=0): count holds; tc <= 0.
- Latency: tc is asserted in the cycle after the edge that performed the terminal step.
- Arithmetic: CNT_W-bit unsigned. Up counting never passes 2^CNT_W-1 because goal <= 2^CNT_W-1 forces terminal first. Down counting never underflows.
- Edge cases:
  - goal=0 in up wrap mode gives tc on every enabled step with count stuck at 0.
  - Down mode after reset starts at 0, so it is terminal immediately: the first enabled step produces tc and reloads goal.
- dir, mode and goal changes apply from the next step; the current count is not adjusted.
- clr or load on a done channel restarts it in the same edge.
- Channels are fully independent. Simultaneous events on different channels do not interact.

Optional Feature:
Macro: MULTI_MODE_COUNTER_PRESCALE_EN.
- Enabled: a shared free-running prescaler counts 0..prescale_div and then wraps. step_tick=1 only in the cycle where the prescaler equals prescale_div, so a channel advances once every prescale_div+1 cycles. prescale_div=0 gives step_tick every cycle. The prescaler resets to 0 on rst and is not affected by clr or load.
- Disabled: no prescaler logic. step_tick is tied to 1 and prescale_div is unused.

Decomposition:
- Shared package (UART_MIKE_pkg):
  - typedef enum logic {CNT_UP, CNT_DOWN} cnt_dir_t;
  - typedef enum logic {CNT_WRAP, CNT_ONESHOT} cnt_mode_t;
  - localparam CNT_W_DEFAULT = 8.
- Sub-module counter_channel: a single channel with scalar ports. The top instantiates it NUM_CH times in a generate loop. The prescaler lives in the top.

Test Plan:
- Reset mid-count: ch0 up, goal=5, counting at count=3; assert rst asynchronously -> count=0, tc=0, done=0 immediately, before the next clk edge.
- Up wrap: ch0 dir=0, mode=0, goal=3, en=1 for 10 cycles -> count 0,1,2,3,0,1,2,3,0,1; tc pulses one cycle after each 3->0 step; done stays 0.
- Down one-shot: ch1 dir=1, mode=1, goal=4, clr then en=1 -> count 4,3,2,1,0, then holds at 0; done=1; a single tc pulse. Then pulse load with load_val=2 -> count=2, done=0, counting resumes.
- Priority: clr=1, load=1, en=1 in the same cycle on ch0 (up) with count=7 -> count=0 next cycle. load=1 with en=1 and load_val=9 -> count=9.
- Goal lowered: up wrap, count=6, goal changed from 10 to 4 -> next enabled step is terminal; count=0 and tc=1.
- Prescale (macro defined): prescale_div=2, ch0 up, goal=255, en held high -> count increments exactly every 3 cycles. With the macro undefined -> count increments every cycle.

Source files
------------

// File: rtl/UART_MIKE_pkg.sv
// Shared types for the UART timing resources: counter direction/mode
// enums and the default counter width.
package UART_MIKE_pkg;

    typedef enum logic {CNT_UP, CNT_DOWN} cnt_dir_t;
    typedef enum logic {CNT_WRAP, CNT_ONESHOT} cnt_mode_t;

    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/multi_mode_counter_channel.sv
// counter_channel: one up/down, wrap/one-shot counter with clear, load,
// registered terminal-count pulse and sticky done flag.
module counter_channel
    import UART_MIKE_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  cnt_dir_t         dir,
    input  cnt_mode_t        mode,
    input  logic [CNT_W-1:0] goal,
    input  logic             step_tick,
    output logic [CNT_W-1:0] count,
    output logic             at_term,
    output logic             tc,
    output logic             done
);

    logic [CNT_W-1:0] start_val;
    logic             step;

    assign start_val = (dir == CNT_DOWN) ? goal : '0;
    // Up uses >= so a goal lowered below the current count still terminates.
    assign at_term   = (dir == CNT_DOWN) ? (count == '0) : (count >= goal);
    assign step      = en && !done && step_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (clr) begin
            count <= start_val;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (step) begin
            if (at_term) begin
                tc <= 1'b1;
                if (mode == CNT_WRAP) begin
                    count <= start_val;
                end else begin
                    done <= 1'b1;
                end
            end else begin
                tc    <= 1'b0;
                count <= (dir == CNT_DOWN) ? count - 1'b1 : count + 1'b1;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_mode_counter.sv
// multi_mode_counter: NUM_CH independent counter channels sharing one clock.
// Define MULTI_MODE_COUNTER_PRESCALE_EN to add a shared step prescaler.
module multi_mode_counter
    import UART_MIKE_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int NUM_CH     = 2,
    parameter int PRESCALE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       clr,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] load_val,
    input  logic [NUM_CH-1:0]       dir,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH*CNT_W-1:0] goal,
    input  logic [PRESCALE_W-1:0]   prescale_div,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       at_term,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       done
);

    logic step_tick;

`ifdef MULTI_MODE_COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_cnt;

    // Free-running 0..prescale_div; >= recovers quickly if the divisor is lowered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_cnt <= '0;
        end else if (prescale_cnt >= prescale_div) begin
            prescale_cnt <= '0;
        end else begin
            prescale_cnt <= prescale_cnt + 1'b1;
        end
    end

    assign step_tick = (prescale_cnt == prescale_div);
`else
    logic prescale_unused;

    assign prescale_unused = ^prescale_div;
    assign step_tick       = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        counter_channel #(
            .CNT_W(CNT_W)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .clr      (clr[i]),
            .load     (load[i]),
            .load_val (load_val[i*CNT_W +: CNT_W]),
            .dir      (cnt_dir_t'(dir[i])),
            .mode     (cnt_mode_t'(mode[i])),
            .goal     (goal[i*CNT_W +: CNT_W]),
            .step_tick(step_tick),
            .count    (count[i*CNT_W +: CNT_W]),
            .at_term  (at_term[i]),
            .tc       (tc[i]),
            .done     (done[i])
        );
    end

endmodule
